// File: rtl/aes_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | aes_pkg : shared constants, FSM encoding and helpers for AES-128 keys    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package aes_pkg;

  localparam int         NR        = 10;
  localparam int         KEY_W     = 128;
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_FIN  = 2'd2
  } ks_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | aes_sbox : single-byte AES S-box (GF(2^8) inverse + affine transform)    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = xtime(aa);
    end
    return acc;
  endfunction

  logic [7:0] w_sq;
  logic [7:0] w_inv;

  // a^254 is the multiplicative inverse, and maps 0 to 0 as the S-box needs
  always_comb begin
    w_sq  = i_byte;
    w_inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      w_sq  = gf_mul(w_sq, w_sq);
      w_inv = gf_mul(w_inv, w_sq);
    end
  end

  assign o_byte = w_inv
                ^ {w_inv[6:0], w_inv[7]}
                ^ {w_inv[5:0], w_inv[7:6]}
                ^ {w_inv[4:0], w_inv[7:5]}
                ^ {w_inv[3:0], w_inv[7:4]}
                ^ 8'h63;

endmodule
`default_nettype wire

// File: rtl/key_expand_step.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | key_expand_step : combinational AES-128 round-key step(rk, rcon)         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module key_expand_step
  import aes_pkg::*;
(
  input  logic [KEY_W-1:0] i_rk,
  input  logic [7:0]       i_rcon,
  output logic [KEY_W-1:0] o_rk
);

  logic [31:0] w_rot;
  logic [31:0] w_sub;
  logic [31:0] w_t;
  logic [31:0] w_w0;
  logic [31:0] w_w1;
  logic [31:0] w_w2;
  logic [31:0] w_w3;

  assign w_rot = rot_word(i_rk[31:0]);

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .i_byte (w_rot[8*b +: 8]),
      .o_byte (w_sub[8*b +: 8])
    );
  end

  assign w_t  = w_sub ^ {i_rcon, 24'h000000};
  assign w_w0 = i_rk[127:96] ^ w_t;
  assign w_w1 = i_rk[95:64]  ^ w_w0;
  assign w_w2 = i_rk[63:32]  ^ w_w1;
  assign w_w3 = i_rk[31:0]   ^ w_w2;
  assign o_rk = {w_w0, w_w1, w_w2, w_w3};

endmodule
`default_nettype wire

// File: rtl/aes_key_schedule.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | aes_key_schedule : iterative AES-128 key expansion, one key per handshake|
// | Optional round-key store enabled by macro AES_KEY_STORE_EN.              |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module aes_key_schedule
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  output logic             busy,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [3:0]       rk_idx,
  output logic [KEY_W-1:0] rk_out,
  output logic             done
`ifdef AES_KEY_STORE_EN
  ,
  input  logic [3:0]       rd_idx,
  output logic [KEY_W-1:0] rd_key
`endif
);

  ks_state_e        state_q, state_d;
  logic [KEY_W-1:0] rk_q, rk_d;
  logic [7:0]       rcon_q, rcon_d;
  logic [3:0]       idx_q, idx_d;
  logic             busy_q, rk_valid_q, done_q;
  logic [KEY_W-1:0] w_rk_next;
  logic             w_accept;

  key_expand_step u_step (
    .i_rk   (rk_q),
    .i_rcon (rcon_q),
    .o_rk   (w_rk_next)
  );

  assign w_accept = rk_valid_q && rk_ready;

  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    rcon_d  = rcon_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rk_d    = key_in;
          rcon_d  = RCON_INIT;
          idx_d   = 4'd0;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (w_accept) begin
          if (idx_q == 4'(NR)) begin
            state_d = ST_FIN;
          end else begin
            rk_d   = w_rk_next;
            rcon_d = xtime(rcon_q);
            idx_d  = idx_q + 4'd1;
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rk_q       <= '0;
      rcon_q     <= 8'h00;
      idx_q      <= 4'd0;
      busy_q     <= 1'b0;
      rk_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rk_q       <= rk_d;
      rcon_q     <= rcon_d;
      idx_q      <= idx_d;
      busy_q     <= (state_d != ST_IDLE);
      rk_valid_q <= (state_d == ST_EMIT);
      done_q     <= (state_d == ST_FIN);
    end
  end

  assign busy     = busy_q;
  assign rk_valid = rk_valid_q;
  assign rk_idx   = idx_q;
  assign rk_out   = rk_q;
  assign done     = done_q;

`ifdef AES_KEY_STORE_EN
  logic [KEY_W-1:0] store_q [NR+1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= NR; i++) store_q[i] <= '0;
    end else if (w_accept) begin
      store_q[idx_q] <= rk_q;
    end
  end

  assign rd_key = (rd_idx <= 4'(NR)) ? store_q[rd_idx] : '0;
`endif

endmodule
`default_nettype wire

// File: doc/aes_key_schedule.md
# aes_key_schedule

Iterative AES-128 key expansion engine that sits directly upstream of the encryption round datapath. It feeds the round key input of each round stage. On a start command it latches the 128-bit cipher key, then emits round keys 0..10 in order, one per accepted valid/ready handshake. It computes one expansion step per accepted key, so it needs no precomputed key table.

## Interface
- `NR`, 10: number of rounds. Round keys emitted = NR+1. Only 10 (AES-128) is supported.
- `KEY_W`, 128: cipher-key and round-key width.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a new expansion. Sampled only in IDLE.
- `key_in`  in  128  cipher key, captured on the accepted start cycle.
- `busy`  out  1  high whenever the state is not IDLE.
- `rk_valid`  out  1  `rk_out`/`rk_idx` hold a valid round key.
- `rk_ready`  in  1  consumer accepts the key this cycle.
- `rk_idx`  out  4  round index 0..NR of `rk_out`.
- `rk_out`  out  128  round key. Word w0 = [127:96], w3 = [31:0].
- `done`  out  1  one-cycle pulse after round key NR is accepted.
- `rd_idx`  in  4  random-access read index (only with `AES_KEY_STORE_EN`).
- `rd_key`  out  128  stored round key `rd_idx` (only with `AES_KEY_STORE_EN`).

## Operation
- The FSM has three states: IDLE, EMIT, FIN.
- **IDLE:** `rk_valid`=0.
  - On `start`=1: `rk` ← `key_in`, `idx` ← 0, `rcon` ← 8'h01, then go to EMIT.
- **EMIT:** `rk_valid`=1.
  - `rk_out`, `rk_idx` and `rk_valid` are held stable until `rk_valid`&&`rk_ready`.
  - On a handshake with `idx`==NR: go to FIN.
  - On any other handshake: `rk` ← step(`rk`, `rcon`), `rcon` ← xtime(`rcon`), `idx` ← `idx`+1.
- **FIN:** `done`=1 for exactly one cycle, then unconditionally go to IDLE.
- step(rk, rcon):
  - t = SubWord(RotWord(w3)) ^ {rcon, 24'h0}
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'
- xtime(r) = {r[6:0],1'b0} ^ (r[7] ? 8'h1B : 8'h00).
  - Resulting Rcon sequence: 01,02,04,08,10,20,40,80,1B,36.
- `start` asserted outside IDLE is ignored, with no queuing.
- `rst` mid-operation aborts immediately: next state IDLE, no `done` pulse.
- Reset values: `busy`=0, `rk_valid`=0, `rk_idx`=0, `rk_out`=0, `done`=0, `rd_key`=0.
  - The internal `rk`, `rcon` and key store are also cleared.

## Timing
- Start accepted at edge t: `rk_valid`=1 with `rk_idx`=0 from cycle t+1.
- With `rk_ready` held high, keys 0..10 appear on cycles t+1..t+11.
  - `done` is high on cycle t+12.
  - `busy` is low and a new `start` is accepted from cycle t+13.
- Throughput is one round key per cycle. The combinational path is one S-box plus XOR chain, registered every cycle.
- Backpressure has no latency penalty. Key k+1 is valid the cycle after key k is accepted.

## Configuration
- Macro: `AES_KEY_STORE_EN`.
- **Defined:**
  - Every accepted round key is also written into an 11×128 register store at index `idx`.
  - `rd_key` = store[`rd_idx`] (combinational read), valid for any `rd_idx` ≤ NR once that index has been written.
  - `rd_idx` > NR returns 0.
  - The store keeps its contents after `done`, which supports reverse-order decrypt use.
  - The store is overwritten by the next expansion.
- **Undefined:** the `rd_idx`/`rd_key` ports and the store do not exist.

## Structure
- Package `aes_pkg`:
  - `NR`, `KEY_W`, the FSM state enum, `RCON_INIT` (8'h01).
  - `xtime` and `rot_word` functions.
- Sub-module `key_expand_step`: purely combinational step(rk, rcon).
  - Instantiates four instances of the existing single-byte S-box used by `subBytes`.
  - Top level contains the FSM, the `rk`/`rcon`/`idx` registers and the optional store.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c with `rk_ready`=1:
  - key 0 = input key.
  - key 1 = a0fafe1788542cb123a339392a6c7605.
  - key 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - `done` at t+12.
- Random `rk_ready` backpressure on the same key: `rk_out`/`rk_idx` stable while stalled, and all 11 keys match the first test in order with no duplicates.
- `start` pulsed during EMIT with a different key: ignored, and the output sequence is unchanged.
- `rst` asserted at `rk_idx`=5: next cycle `busy`=0, `rk_valid`=0, no `done`. A fresh `start` then restarts at `rk_idx`=0.
- Two back-to-back expansions (start at t+13): the second key's schedule is correct, and its `rcon` restarts at 01.
- With `AES_KEY_STORE_EN` defined, after `done`: `rd_idx`=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6, and `rd_idx`=11 gives 0.
